branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Tracks every fetched instruction's prediction (pred_pc, BHSR) from IF until it resolves in EX.
//  Computes the actual next PC in EX, detects mispredictions and drives flush plus redirect to fetch.
//  Drives the training interface back into the gshare BTB.
//  Sits between the BTB/PC-select logic (upstream) and the EX-stage branch comparator.
// PARAMETERS
//  DEPTH   4   in-flight prediction FIFO entries (power of 2, >=2)
//  PTR_W   2   log2(DEPTH)
//  HIST_W  5   global history (BHSR) width
//  CNT_W   32  statistics counter width
// PORTS
//  clk             in   1       clock
//  reset           in   1       synchronous, active-high reset
//  fetch_valid     in   1       IF pushes {fetch_pc, pred_pc, pred_bhsr} this cycle
//  fetch_pc        in   32      PC of fetched instruction
//  pred_pc         in   32      BTB predicted next PC
//  pred_bhsr       in   HIST_W  BHSR used for the prediction index
//  fifo_full       out  1       no free entry; IF must stall
//  ex_valid        in   1       one instruction leaves EX this cycle (pops oldest entry)
//  ex_is_branch    in   1       conditional branch
//  ex_is_jal       in   1       jal
//  ex_is_jalr      in   1       jalr
//  ex_bcond        in   1       ALU branch condition
//  ex_pc_plus_imm  in   32      branch/jal target
//  ex_reg_plus_imm in   32      jalr target (bit0 already cleared)
//  flush           out  1       squash IF/ID/EX younger instructions (1-cycle pulse)
//  redirect_pc     out  32      correct next PC, valid while flush=1
//  upd_valid       out  1       train BTB/PHT this cycle
//  upd_pc, upd_target out 32    resolved PC / actual target
//  upd_bhsr        out  HIST_W  BHSR recorded at fetch
//  upd_taken       out  1       actual direction (jal/jalr always 1)
//  resolve_count, mispredict_count  out  CNT_W  statistics
//  err_overflow, err_underflow      out  1      sticky protocol-error flags
// BEHAVIOUR
//  - Reset: FIFO empty, state IDLE, every output 0 (fifo_full 0, redirect_pc 0, counters 0, errs 0).
//  - FIFO: circular, PTR_W-bit pointers plus occupancy count 0..DEPTH.
//    fifo_full = (count==DEPTH), combinational.
//  - IDLE, ex_valid, FIFO non-empty: pop head. taken = (branch&bcond)|jal|jalr;
//    target = jalr ? reg_plus_imm : pc_plus_imm; actual = taken ? target : head.pc+4 (mod 2^32).
//  - Mispredict when actual != head.pred_pc, any instruction type included.
//  - Registered outputs, 1-cycle latency: the cycle after resolve, upd_* are valid
//    (upd_valid only for branch/jal/jalr) and resolve_count += 1.
//    On mispredict, the same cycle also has flush=1, redirect_pc=actual, mispredict_count += 1.
//  - Mispredict edge: FIFO cleared entirely, including any same-cycle push; next state RECOVER.
//  - RECOVER (exactly 1 cycle, flush=1): fetch_valid and ex_valid ignored
//    (wrong-path; no push, no pop, no error); next state IDLE.
//  - Simultaneous push+pop in IDLE without mispredict: both occur, count unchanged; legal when full.
//  - Push when full and no same-cycle pop: dropped, err_overflow<=1 (sticky until reset).
//  - ex_valid when empty: no pop, no update, err_underflow<=1 (sticky).
//  - Counters wrap at 2^CNT_W. Reset mid-operation overrides everything: FIFO empty, state IDLE, flush 0.
//  - redirect_pc holds its last value when flush=0; upd_* are don't-care when upd_valid=0.
// TESTING
//  1. Push pc=0x0,pred=0x4 (add); pop ex_valid non-control -> no flush, upd_valid=0, resolve_count=1.
//  2. Push pc=0x10,pred=0x14; pop branch bcond=1 pc_plus_imm=0x40 -> next cycle flush=1,
//     redirect_pc=0x40, upd_taken=1, upd_target=0x40, mispredict_count=1.
//  3. Push pc=0x20,pred=0x80,bhsr=5'h13; pop jalr reg_plus_imm=0x80 -> no flush,
//     upd_valid=1, upd_bhsr=5'h13, upd_taken=1.
//  4. Push 4 entries -> fifo_full=1; 5th push alone -> err_overflow=1, count stays 4;
//     push+pop same cycle -> accepted, no error.
//  5. Mispredict with 3 younger entries + same-cycle push -> FIFO empty;
//     RECOVER-cycle fetch_valid/ex_valid ignored; cycle after, push accepted.
//  6. Assert reset during RECOVER with 2 entries -> next cycle flush=0, fifo empty, counters 0, errs 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Holds in-flight fetch predictions, resolves them in EX, flushes
//            and redirects on mispredict, and trains the gshare BTB.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int HIST_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic [31:0]       fetch_pc,
    input  logic [31:0]       pred_pc,
    input  logic [HIST_W-1:0] pred_bhsr,
    output logic              fifo_full,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic              ex_is_jal,
    input  logic              ex_is_jalr,
    input  logic              ex_bcond,
    input  logic [31:0]       ex_pc_plus_imm,
    input  logic [31:0]       ex_reg_plus_imm,
    output logic              flush,
    output logic [31:0]       redirect_pc,
    output logic              upd_valid,
    output logic [31:0]       upd_pc,
    output logic [31:0]       upd_target,
    output logic [HIST_W-1:0] upd_bhsr,
    output logic              upd_taken,
    output logic [CNT_W-1:0]  resolve_count,
    output logic [CNT_W-1:0]  mispredict_count,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam logic [PTR_W:0] C_FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    logic [31:0]        pc_mem_q   [DEPTH];
    logic [31:0]        pred_mem_q [DEPTH];
    logic [HIST_W-1:0]  bhsr_mem_q [DEPTH];

    logic               flush_q, flush_d;
    logic [31:0]        redirect_q, redirect_d;
    logic               upd_valid_q, upd_valid_d;
    logic [31:0]        upd_pc_q, upd_pc_d;
    logic [31:0]        upd_target_q, upd_target_d;
    logic [HIST_W-1:0]  upd_bhsr_q, upd_bhsr_d;
    logic               upd_taken_q, upd_taken_d;
    logic [CNT_W-1:0]   resolve_q, resolve_d;
    logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;
    logic               err_ov_q, err_ov_d;
    logic               err_uf_q, err_uf_d;

    logic               w_empty;
    logic               w_full;
    logic               w_is_ctrl;
    logic               w_taken;
    logic [31:0]        w_target;
    logic [31:0]        w_actual;
    logic [31:0]        w_head_pc;
    logic [31:0]        w_head_pred;
    logic               w_do_pop;
    logic               w_do_push;
    logic               w_mispredict;

    assign w_empty     = (count_q == '0);
    assign w_full      = (count_q == C_FULL_COUNT);
    assign w_head_pc   = pc_mem_q[rd_ptr_q];
    assign w_head_pred = pred_mem_q[rd_ptr_q];
    assign w_is_ctrl   = ex_is_branch | ex_is_jal | ex_is_jalr;
    assign w_taken     = (ex_is_branch & ex_bcond) | ex_is_jal | ex_is_jalr;
    assign w_target    = ex_is_jalr ? ex_reg_plus_imm : ex_pc_plus_imm;
    assign w_actual    = w_taken ? w_target : (w_head_pc + 32'd4);

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        flush_d       = 1'b0;
        redirect_d    = redirect_q;
        upd_valid_d   = 1'b0;
        upd_pc_d      = upd_pc_q;
        upd_target_d  = upd_target_q;
        upd_bhsr_d    = upd_bhsr_q;
        upd_taken_d   = upd_taken_q;
        resolve_d     = resolve_q;
        mispred_cnt_d = mispred_cnt_q;
        err_ov_d      = err_ov_q;
        err_uf_d      = err_uf_q;
        w_do_pop      = 1'b0;
        w_do_push     = 1'b0;
        w_mispredict  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                w_do_pop     = ex_valid & ~w_empty;
                w_mispredict = w_do_pop & (w_actual != w_head_pred);
                // A same-cycle pop frees the slot, so a push into a full FIFO is legal then.
                w_do_push    = fetch_valid & (~w_full | w_do_pop) & ~w_mispredict;

                if (ex_valid && w_empty) begin
                    err_uf_d = 1'b1;
                end
                if (fetch_valid && w_full && !w_do_pop) begin
                    err_ov_d = 1'b1;
                end

                if (w_do_pop) begin
                    upd_valid_d  = w_is_ctrl;
                    upd_pc_d     = w_head_pc;
                    upd_target_d = w_actual;
                    upd_bhsr_d   = bhsr_mem_q[rd_ptr_q];
                    upd_taken_d  = w_taken;
                    resolve_d    = resolve_q + CNT_W'(1);
                end

                if (w_mispredict) begin
                    flush_d       = 1'b1;
                    redirect_d    = w_actual;
                    mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
                    rd_ptr_d      = '0;
                    wr_ptr_d      = '0;
                    count_d       = '0;
                    state_d       = ST_RECOVER;
                end else begin
                    if (w_do_pop) begin
                        rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    end
                    if (w_do_push) begin
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    end
                    case ({w_do_push, w_do_pop})
                        2'b10:   count_d = count_q + (PTR_W+1)'(1);
                        2'b01:   count_d = count_q - (PTR_W+1)'(1);
                        default: count_d = count_q;
                    endcase
                end
            end

            // Wrong-path fetch/EX traffic is discarded while the flush propagates.
            ST_RECOVER: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            flush_q       <= 1'b0;
            redirect_q    <= '0;
            upd_valid_q   <= 1'b0;
            upd_pc_q      <= '0;
            upd_target_q  <= '0;
            upd_bhsr_q    <= '0;
            upd_taken_q   <= 1'b0;
            resolve_q     <= '0;
            mispred_cnt_q <= '0;
            err_ov_q      <= 1'b0;
            err_uf_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            upd_valid_q   <= upd_valid_d;
            upd_pc_q      <= upd_pc_d;
            upd_target_q  <= upd_target_d;
            upd_bhsr_q    <= upd_bhsr_d;
            upd_taken_q   <= upd_taken_d;
            resolve_q     <= resolve_d;
            mispred_cnt_q <= mispred_cnt_d;
            err_ov_q      <= err_ov_d;
            err_uf_q      <= err_uf_d;
        end
    end

    // Entry storage needs no reset: occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc;
            pred_mem_q[wr_ptr_q] <= pred_pc;
            bhsr_mem_q[wr_ptr_q] <= pred_bhsr;
        end
    end

    assign fifo_full        = w_full;
    assign flush            = flush_q;
    assign redirect_pc      = redirect_q;
    assign upd_valid        = upd_valid_q;
    assign upd_pc           = upd_pc_q;
    assign upd_target       = upd_target_q;
    assign upd_bhsr         = upd_bhsr_q;
    assign upd_taken        = upd_taken_q;
    assign resolve_count    = resolve_q;
    assign mispredict_count = mispred_cnt_q;
    assign err_overflow     = err_ov_q;
    assign err_underflow    = err_uf_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit with a
//            queue-based reference model checked after every clock edge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

    localparam int HIST_W = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              fetch_valid;
    logic [31:0]       fetch_pc;
    logic [31:0]       pred_pc;
    logic [HIST_W-1:0] pred_bhsr;
    logic              fifo_full;
    logic              ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, ex_bcond;
    logic [31:0]       ex_pc_plus_imm, ex_reg_plus_imm;
    logic              flush;
    logic [31:0]       redirect_pc;
    logic              upd_valid;
    logic [31:0]       upd_pc, upd_target;
    logic [HIST_W-1:0] upd_bhsr;
    logic              upd_taken;
    logic [CNT_W-1:0]  resolve_count, mispredict_count;
    logic              err_overflow, err_underflow;

    branch_resolve_unit #(.DEPTH(4), .PTR_W(2), .HIST_W(HIST_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .pred_pc(pred_pc), .pred_bhsr(pred_bhsr),
        .fifo_full(fifo_full),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
        .ex_bcond(ex_bcond), .ex_pc_plus_imm(ex_pc_plus_imm), .ex_reg_plus_imm(ex_reg_plus_imm),
        .flush(flush), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_bhsr(upd_bhsr),
        .upd_taken(upd_taken),
        .resolve_count(resolve_count), .mispredict_count(mispredict_count),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       pred;
        logic [HIST_W-1:0] bhsr;
    } ent_t;

    ent_t              mq[$];
    bit                m_recover;
    logic              e_flush, e_upd_valid, e_upd_taken, e_ov, e_uf;
    logic [31:0]       e_redirect, e_upd_pc, e_upd_target;
    logic [HIST_W-1:0] e_upd_bhsr;
    logic [CNT_W-1:0]  e_resolve, e_mispred;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: the FIFO is a plain queue; one call models one clock edge.
    task automatic model_step();
        ent_t        h;
        logic        tk, misp;
        logic [31:0] act;
        if (reset) begin
            mq.delete();
            m_recover = 0;
            e_flush = 0; e_redirect = 0; e_upd_valid = 0; e_upd_pc = 0; e_upd_target = 0;
            e_upd_bhsr = 0; e_upd_taken = 0; e_resolve = 0; e_mispred = 0; e_ov = 0; e_uf = 0;
        end else if (m_recover) begin
            m_recover = 0;
            e_flush = 0;
            e_upd_valid = 0;
        end else begin
            misp = 0;
            e_flush = 0;
            e_upd_valid = 0;
            if (ex_valid) begin
                if (mq.size() == 0) begin
                    e_uf = 1;
                end else begin
                    h   = mq.pop_front();
                    tk  = (ex_is_branch && ex_bcond) || ex_is_jal || ex_is_jalr;
                    act = tk ? (ex_is_jalr ? ex_reg_plus_imm : ex_pc_plus_imm) : h.pc + 32'd4;
                    e_resolve    = e_resolve + 1;
                    e_upd_valid  = ex_is_branch || ex_is_jal || ex_is_jalr;
                    e_upd_pc     = h.pc;
                    e_upd_target = act;
                    e_upd_bhsr   = h.bhsr;
                    e_upd_taken  = tk;
                    if (act != h.pred) begin
                        misp = 1;
                        e_flush = 1;
                        e_redirect = act;
                        e_mispred = e_mispred + 1;
                        mq.delete();
                        m_recover = 1;
                    end
                end
            end
            if (fetch_valid && !misp) begin
                if (mq.size() < 4) mq.push_back('{pc: fetch_pc, pred: pred_pc, bhsr: pred_bhsr});
                else e_ov = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("fifo_full", fifo_full, mq.size() == 4);
        chk("flush", flush, e_flush);
        chk("redirect_pc", redirect_pc, e_redirect);
        chk("upd_valid", upd_valid, e_upd_valid);
        if (e_upd_valid) begin
            chk("upd_pc", upd_pc, e_upd_pc);
            chk("upd_target", upd_target, e_upd_target);
            chk("upd_bhsr", upd_bhsr, e_upd_bhsr);
            chk("upd_taken", upd_taken, e_upd_taken);
        end
        chk("resolve_count", resolve_count, e_resolve);
        chk("mispredict_count", mispredict_count, e_mispred);
        chk("err_overflow", err_overflow, e_ov);
        chk("err_underflow", err_underflow, e_uf);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic clr();
        fetch_valid = 0; fetch_pc = 0; pred_pc = 0; pred_bhsr = 0;
        ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_bcond = 0;
        ex_pc_plus_imm = 0; ex_reg_plus_imm = 0;
    endtask

    task automatic set_push(input logic [31:0] pc, input logic [31:0] pred, input logic [HIST_W-1:0] bh);
        fetch_valid = 1; fetch_pc = pc; pred_pc = pred; pred_bhsr = bh;
    endtask

    // kind: 0 plain, 1 branch, 2 jal, 3 jalr
    task automatic set_pop(input int kind, input logic bc, input logic [31:0] pimm, input logic [31:0] rimm);
        ex_valid = 1; ex_is_branch = (kind == 1); ex_is_jal = (kind == 2); ex_is_jalr = (kind == 3);
        ex_bcond = bc; ex_pc_plus_imm = pimm; ex_reg_plus_imm = rimm;
    endtask

    initial begin
        clr();
        reset = 1;
        tick(); tick();
        chk("rst_redirect_lit", redirect_pc, 32'h0);
        chk("rst_full_lit", fifo_full, 1'b0);
        reset = 0;

        // 1: plain instruction, correctly predicted
        clr(); set_push(32'h0, 32'h4, 5'h00); tick();
        clr(); set_pop(0, 0, 0, 0); tick();
        chk("t1_flush_lit", flush, 1'b0);
        chk("t1_updv_lit", upd_valid, 1'b0);
        chk("t1_resolve_lit", resolve_count, 32'd1);

        // 2: taken branch predicted fall-through
        clr(); set_push(32'h10, 32'h14, 5'h01); tick();
        clr(); set_pop(1, 1, 32'h40, 0); tick();
        chk("t2_flush_lit", flush, 1'b1);
        chk("t2_redirect_lit", redirect_pc, 32'h40);
        chk("t2_taken_lit", upd_taken, 1'b1);
        chk("t2_target_lit", upd_target, 32'h40);
        chk("t2_mcount_lit", mispredict_count, 32'd1);
        clr(); tick();

        // 3: correctly predicted jalr
        clr(); set_push(32'h20, 32'h80, 5'h13); tick();
        clr(); set_pop(3, 0, 32'h999, 32'h80); tick();
        chk("t3_flush_lit", flush, 1'b0);
        chk("t3_updv_lit", upd_valid, 1'b1);
        chk("t3_bhsr_lit", upd_bhsr, 5'h13);
        chk("t3_redirect_hold_lit", redirect_pc, 32'h40);

        // jal correct, then wrap of pc+4 at the top of the address space
        clr(); set_push(32'h500, 32'h600, 5'h07); tick();
        clr(); set_pop(2, 0, 32'h600, 0); tick();
        clr(); set_push(32'hFFFF_FFFC, 32'h0, 5'h1F); tick();
        clr(); set_pop(0, 0, 0, 0); tick();
        chk("wrap_flush_lit", flush, 1'b0);

        // 4: fill, overflow, push+pop while full
        for (int i = 0; i < 4; i++) begin
            clr(); set_push(32'h100 + 32'(i * 4), 32'h104 + 32'(i * 4), 5'(i)); tick();
        end
        chk("t4_full_lit", fifo_full, 1'b1);
        chk("t4_noov_lit", err_overflow, 1'b0);
        clr(); set_push(32'h700, 32'h704, 5'h02); tick();
        chk("t4_ov_lit", err_overflow, 1'b1);
        chk("t4_still_full_lit", fifo_full, 1'b1);
        clr(); set_push(32'h200, 32'h204, 5'h03); set_pop(0, 0, 0, 0); tick();
        chk("t4_pushpop_full_lit", fifo_full, 1'b1);
        chk("t4_pushpop_flush_lit", flush, 1'b0);

        // 5: mispredict with 3 younger entries and a same-cycle push
        clr(); set_push(32'h999, 32'h99d, 5'h04); set_pop(1, 1, 32'h300, 0); tick();
        chk("t5_flush_lit", flush, 1'b1);
        chk("t5_redirect_lit", redirect_pc, 32'h300);
        chk("t5_empty_lit", fifo_full, 1'b0);
        clr(); set_push(32'h888, 32'h88c, 5'h05); set_pop(0, 0, 0, 0); tick();
        chk("t5_recover_no_uf_lit", err_underflow, 1'b0);
        clr(); set_push(32'h400, 32'h404, 5'h06); tick();
        clr(); set_pop(0, 0, 0, 0); tick();
        chk("t5_pop_ok_lit", err_underflow, 1'b0);
        chk("t5_no_flush_lit", flush, 1'b0);
        clr(); set_pop(0, 0, 0, 0); tick();
        chk("t5_underflow_lit", err_underflow, 1'b1);

        // 6: reset asserted during RECOVER
        clr(); set_push(32'h40, 32'h44, 5'h08); tick();
        clr(); set_push(32'h44, 32'h48, 5'h09); tick();
        clr(); set_push(32'h48, 32'h4c, 5'h0a); set_pop(1, 1, 32'h1000, 0); tick();
        chk("t6_flush_lit", flush, 1'b1);
        clr(); reset = 1; set_push(32'h50, 32'h54, 5'h0b); tick();
        reset = 0;
        chk("t6_flush0_lit", flush, 1'b0);
        chk("t6_resolve0_lit", resolve_count, 32'd0);
        chk("t6_mcount0_lit", mispredict_count, 32'd0);
        chk("t6_ov0_lit", err_overflow, 1'b0);
        chk("t6_uf0_lit", err_underflow, 1'b0);
        clr(); set_pop(0, 0, 0, 0); tick();
        chk("t6_empty_uf_lit", err_underflow, 1'b1);
        clr(); tick();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
